// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: GMII transmit framer for the 125 MHz GTX domain.
// Wraps a valid/ready/last byte stream with preamble, SFD, optional
// minimum-size padding, CRC-32 FCS and a fixed inter-frame gap.
//
// Build option: define GMII_TX_PAD_EN to zero-pad frames shorter than
// MIN_FRAME payload bytes. Without it the PAD state logic is left out and
// every frame goes straight from DATA to FCS.
module gmii_tx_framer #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_FRAME = 60
) (
    input  logic       clk_125,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_err,
    output logic       in_ready,
    output logic [7:0] gm_txd,
    output logic       gm_tx_en,
    output logic       gm_tx_er,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_e;

    localparam logic [7:0]  PreLast  = 8'd6;
    localparam logic [7:0]  FcsLast  = 8'd3;
    // The IDLE cycle before PRE supplies one gap cycle, so IFG covers the rest.
    localparam logic [7:0]  IfgLast  = 8'(IFG_BYTES - 1);
    localparam bit          IfgState = (IFG_BYTES > 1);
    localparam logic [31:0] CrcInit  = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPoly  = 32'hEDB8_8320;

`ifdef GMII_TX_PAD_EN
    localparam logic [10:0] MinFrameW = 11'(MIN_FRAME);
`else
    logic unused_min_frame;
    assign unused_min_frame = ^MIN_FRAME;
`endif

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] byte_cnt_inc;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_val;
    logic [7:0]  txd_d;
    logic        tx_en_d;
    logic        tx_er_d;
    logic        frame_done_d;
    logic        xfer;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    assign in_ready     = (state_q == StData);
    assign busy         = (state_q != StIdle);
    assign xfer         = in_valid & in_ready;
    assign fcs_val      = ~crc_q;
    // Byte count saturates so oversize frames cannot wrap into the pad compare.
    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

    // State register.
    always_ff @(posedge clk_125) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                if (phase_q == PreLast) begin
                    state_d = StSfd;
                end
            end
            StSfd: begin
                state_d = StData;
            end
            StData: begin
                if (xfer && in_last) begin
`ifdef GMII_TX_PAD_EN
                    state_d = (byte_cnt_inc < MinFrameW) ? StPad : StFcs;
`else
                    state_d = StFcs;
`endif
                end
            end
`ifdef GMII_TX_PAD_EN
            StPad: begin
                if (byte_cnt_inc >= MinFrameW) begin
                    state_d = StFcs;
                end
            end
`endif
            StFcs: begin
                if (phase_q == FcsLast) begin
                    state_d = IfgState ? StIfg : StIdle;
                end
            end
            StIfg: begin
                if (phase_q >= IfgLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and datapath next values; everything below lands in registers.
    always_comb begin
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        crc_d        = crc_q;
        byte_cnt_d   = byte_cnt_q;

        // Phase counter restarts on every state change; IFG starts at 1
        // because the following IDLE cycle is also part of the gap.
        if (state_d != state_q) begin
            phase_d = (state_d == StIfg) ? 8'd1 : 8'd0;
        end else begin
            phase_d = phase_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                phase_d = (state_d == StPre) ? 8'd0 : phase_q;
            end
            StPre: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
            end
            StSfd: begin
                txd_d      = 8'hD5;
                tx_en_d    = 1'b1;
                crc_d      = CrcInit;
                byte_cnt_d = 11'd0;
            end
            StData: begin
                tx_en_d = 1'b1;
                if (xfer) begin
                    txd_d      = in_data;
                    tx_er_d    = in_err;
                    crc_d      = crc32_byte(crc_q, in_data);
                    byte_cnt_d = byte_cnt_inc;
                end else begin
                    // Underrun: keep the carrier up but poison the frame.
                    txd_d   = 8'h00;
                    tx_er_d = 1'b1;
                end
            end
`ifdef GMII_TX_PAD_EN
            StPad: begin
                txd_d      = 8'h00;
                tx_en_d    = 1'b1;
                crc_d      = crc32_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc;
            end
`endif
            StFcs: begin
                tx_en_d = 1'b1;
                unique case (phase_q[1:0])
                    2'd0:    txd_d = fcs_val[7:0];
                    2'd1:    txd_d = fcs_val[15:8];
                    2'd2:    txd_d = fcs_val[23:16];
                    default: txd_d = fcs_val[31:24];
                endcase
                frame_done_d = (phase_q == FcsLast);
            end
            StIfg: begin
                tx_en_d = 1'b0;
            end
            default: begin
                tx_en_d = 1'b0;
            end
        endcase
    end

    // Registered GMII outputs, CRC and counters.
    always_ff @(posedge clk_125) begin
        if (reset) begin
            gm_txd     <= 8'h00;
            gm_tx_en   <= 1'b0;
            gm_tx_er   <= 1'b0;
            frame_done <= 1'b0;
            crc_q      <= CrcInit;
            byte_cnt_q <= 11'd0;
            phase_q    <= 8'd0;
        end else begin
            gm_txd     <= txd_d;
            gm_tx_en   <= tx_en_d;
            gm_tx_er   <= tx_er_d;
            frame_done <= frame_done_d;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table of frames checked against a byte-level
// model of the wire, plus hand sequences for start latency, back-to-back
// gap and reset in mid-frame.
module tb_gmii_tx_framer;

    typedef struct {
        int         len;
        logic [7:0] seed;
        logic [7:0] step;
        int         gap_at;
        int         gap_len;
        int         err_at;
        int         exp_len;
        logic [31:0] exp_fcs;
    } vec_t;

`ifdef GMII_TX_PAD_EN
    localparam int PadTo = 60;
`else
    localparam int PadTo = 0;
`endif

    logic       clk_125 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_err = 1'b0;
    logic       in_ready;
    logic [7:0] gm_txd;
    logic       gm_tx_en;
    logic       gm_tx_er;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_pass = 0;
    bit abort = 1'b0;

    logic [7:0] exp_d[$];
    logic       exp_er[$];

    logic [7:0] mon_d[$];
    logic       mon_er[$];
    logic       mon_done[$];
    int         mon_len[$];
    int         mon_gap[$];
    logic [7:0] cur_d[$];
    logic       cur_er[$];
    logic       cur_done[$];
    int         gap_run = 0;
    int         cur_gap = 0;

    vec_t tbl[5];

    gmii_tx_framer dut (
        .clk_125   (clk_125),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_err    (in_err),
        .in_ready  (in_ready),
        .gm_txd    (gm_txd),
        .gm_tx_en  (gm_tx_en),
        .gm_tx_er  (gm_tx_er),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #4 clk_125 = ~clk_125;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input logic [7:0] step, input int i);
        return 8'(int'(seed) + i * int'(step));
    endfunction

    // Serial (bit at a time) reference CRC-32.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_fcs(input int len, input logic [7:0] seed,
                                            input logic [7:0] step);
        logic [31:0] r;
        int total;
        r = 32'hFFFFFFFF;
        total = (len < PadTo) ? PadTo : len;
        for (int i = 0; i < total; i++) begin
            r = crc_upd(r, (i < len) ? pat(seed, step, i) : 8'h00);
        end
        return ~r;
    endfunction

    task automatic build_expected(input int len, input logic [7:0] seed, input logic [7:0] step,
                                  input int gap_at, input int gap_len, input int err_at);
        logic [31:0] f;
        int total;
        exp_d.delete();
        exp_er.delete();
        for (int i = 0; i < 7; i++) begin exp_d.push_back(8'h55); exp_er.push_back(1'b0); end
        exp_d.push_back(8'hD5); exp_er.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    exp_d.push_back(8'h00); exp_er.push_back(1'b1);
                end
            end
            exp_d.push_back(pat(seed, step, i));
            exp_er.push_back(i == err_at);
        end
        total = (len < PadTo) ? PadTo : len;
        for (int i = len; i < total; i++) begin exp_d.push_back(8'h00); exp_er.push_back(1'b0); end
        f = ref_fcs(len, seed, step);
        for (int i = 0; i < 4; i++) begin exp_d.push_back(f[8*i +: 8]); exp_er.push_back(1'b0); end
    endtask

    // Wire monitor, sampled on the falling edge.
    always @(negedge clk_125) begin
        if (reset) begin
            cur_d.delete(); cur_er.delete(); cur_done.delete();
            gap_run = 0;
        end else if (gm_tx_en) begin
            if (cur_d.size() == 0) cur_gap = gap_run;
            cur_d.push_back(gm_txd); cur_er.push_back(gm_tx_er); cur_done.push_back(frame_done);
            gap_run = 0;
        end else begin
            if (cur_d.size() > 0) begin
                foreach (cur_d[i]) begin
                    mon_d.push_back(cur_d[i]); mon_er.push_back(cur_er[i]);
                    mon_done.push_back(cur_done[i]);
                end
                mon_len.push_back(cur_d.size());
                mon_gap.push_back(cur_gap);
                cur_d.delete(); cur_er.delete(); cur_done.delete();
            end
            gap_run++;
        end
    end

    task automatic send_frame(input int len, input logic [7:0] seed, input logic [7:0] step,
                              input int gap_at, input int gap_len, input int err_at,
                              input bit hold);
        int idx = 0;
        int gaps = gap_len;
        int budget = 5000;
        while (idx < len && !abort && budget > 0) begin
            if (idx == gap_at && gaps > 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = pat(seed, step, idx);
                in_last  = (idx == len - 1);
                in_err   = (idx == err_at);
            end
            @(negedge clk_125);
            if (in_ready) begin
                if (in_valid) idx++;
                else gaps--;
            end
            @(posedge clk_125); #1;
            budget--;
        end
        if (budget == 0) chk("drv_timeout_bytes_sent", idx, len);
        if (!hold || abort) begin
            in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
        end
    endtask

    task automatic check_frame(input string name, input int exp_len, input logic [31:0] exp_fcs,
                               output int gap);
        int n;
        int bad_d = 0;
        int bad_er = 0;
        int done_cnt = 0;
        logic [7:0] d[$];
        logic er[$];
        logic dn[$];
        logic [31:0] act_fcs = 32'h0;
        gap = -1;
        for (int t = 0; t < 3000 && mon_len.size() == 0; t++) @(posedge clk_125);
        if (mon_len.size() == 0) begin
            chk({name, "_frame_seen"}, mon_len.size(), 1);
            return;
        end
        n = mon_len.pop_front();
        gap = mon_gap.pop_front();
        for (int i = 0; i < n; i++) begin
            d.push_back(mon_d.pop_front()); er.push_back(mon_er.pop_front());
            dn.push_back(mon_done.pop_front());
        end
        for (int i = 0; i < n; i++) begin
            if (i >= exp_d.size() || d[i] !== exp_d[i]) bad_d++;
            if (i >= exp_er.size() || er[i] !== exp_er[i]) bad_er++;
            if (dn[i]) done_cnt++;
        end
        if (n < exp_d.size()) begin
            bad_d += exp_d.size() - n;
            bad_er += exp_d.size() - n;
        end
        if (n >= 4) act_fcs = {d[n-1], d[n-2], d[n-3], d[n-4]};
        chk({name, "_en_cycles"}, n, exp_len);
        chk({name, "_txd_bad_bytes"}, bad_d, 0);
        chk({name, "_er_bad_cycles"}, bad_er, 0);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_done_on_last"}, (n > 0) ? dn[n-1] : 1'b0, 1);
        chk({name, "_fcs"}, act_fcs, exp_fcs);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && busy; t++) @(posedge clk_125);
        #1;
    endtask

    initial begin
        int gap;
        int t;

        // len, seed, step, gap_at, gap_len, err_at, exp_len, exp_fcs
        tbl[0] = '{9,  8'h31, 8'h01, -1, 0, -1, 21, 32'hCBF43926};
        tbl[1] = '{1,  8'hAA, 8'h00, -1, 0, -1, 13, 32'h0};
        tbl[2] = '{20, 8'h00, 8'h07,  5, 3, -1, 35, 32'h0};
        tbl[3] = '{16, 8'h10, 8'h01, -1, 0,  9, 28, 32'h0};
        tbl[4] = '{64, 8'hF0, 8'h03, -1, 0, -1, 76, 32'h0};
`ifdef GMII_TX_PAD_EN
        tbl[0].exp_len = 72; tbl[1].exp_len = 72; tbl[2].exp_len = 75; tbl[3].exp_len = 72;
        tbl[0].exp_fcs = ref_fcs(tbl[0].len, tbl[0].seed, tbl[0].step);
`endif
        for (int i = 1; i < 5; i++) tbl[i].exp_fcs = ref_fcs(tbl[i].len, tbl[i].seed, tbl[i].step);

        // Reset state.
        repeat (3) @(posedge clk_125);
        #1;
        chk("rst_txd", gm_txd, 8'h00);
        chk("rst_en", gm_tx_en, 1'b0);
        chk("rst_er", gm_tx_er, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        reset = 1'b0;
        @(posedge clk_125); #1;

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].len, tbl[i].seed, tbl[i].step, tbl[i].gap_at, tbl[i].gap_len,
                       tbl[i].err_at, 1'b0);
            build_expected(tbl[i].len, tbl[i].seed, tbl[i].step, tbl[i].gap_at, tbl[i].gap_len,
                           tbl[i].err_at);
            check_frame($sformatf("vec%0d", i), tbl[i].exp_len, tbl[i].exp_fcs, gap);
        end

        // Start latency: valid seen at edge N, first preamble byte after N+1.
        wait_idle();
        chk("idle_before_start", busy, 1'b0);
        @(posedge clk_125); #1;
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0; in_err = 1'b0;
        @(posedge clk_125); #1;
        chk("start_en_after_N", gm_tx_en, 1'b0);
        chk("start_busy_after_N", busy, 1'b1);
        chk("start_ready_in_pre", in_ready, 1'b0);
        @(posedge clk_125); #1;
        chk("start_txd_after_N1", gm_txd, 8'h55);
        chk("start_en_after_N1", gm_tx_en, 1'b1);
        send_frame(3, 8'h01, 8'h01, -1, 0, -1, 1'b0);
        build_expected(3, 8'h01, 8'h01, -1, 0, -1);
        check_frame("start", (PadTo > 0) ? 72 : 15, ref_fcs(3, 8'h01, 8'h01), gap);

        // Back-to-back 64-byte frames with valid held high.
        wait_idle();
        send_frame(64, 8'h11, 8'h05, -1, 0, -1, 1'b1);
        send_frame(64, 8'h80, 8'h01, -1, 0, -1, 1'b0);
        build_expected(64, 8'h11, 8'h05, -1, 0, -1);
        check_frame("b2b_a", 76, ref_fcs(64, 8'h11, 8'h05), gap);
        build_expected(64, 8'h80, 8'h01, -1, 0, -1);
        check_frame("b2b_b", 76, ref_fcs(64, 8'h80, 8'h01), gap);
        chk("b2b_ifg_cycles", gap, 12);

        // Reset in the middle of DATA.
        wait_idle();
        fork
            send_frame(30, 8'h20, 8'h01, -1, 0, -1, 1'b0);
        join_none
        for (t = 0; t < 100; t++) begin
            @(negedge clk_125);
            if (in_ready) break;
        end
        chk("midrst_reached_data", in_ready, 1'b1);
        repeat (4) @(posedge clk_125);
        #1;
        reset = 1'b1;
        abort = 1'b1;
        @(posedge clk_125); #1;
        chk("midrst_en", gm_tx_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk_125); #1;
        abort = 1'b0;
        chk("midrst_no_partial_frame", mon_len.size(), 0);
        send_frame(12, 8'h5A, 8'h0B, -1, 0, -1, 1'b0);
        build_expected(12, 8'h5A, 8'h0B, -1, 0, -1);
        check_frame("after_rst", (PadTo > 0) ? 72 : 24, ref_fcs(12, 8'h5A, 8'h0B), gap);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
